// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// ---------------
// Single-request memory access controller. It sits between a core's load/store
// path and a word-wide memory with separate address and read-data handshakes.
// Each accepted request is decoded into lanes, issued once to memory, and
// answered with exactly one response. The response carries either the
// extended/merged load result or zero for a store.
//
// Parameters
//   TIMEOUT        : maximum number of stalled cycles allowed in ADDR or RDATA
//                    before the access is aborted with an error; 0 = no limit.
//
// Compile-time option
//   MEM_ALIGN_CHECK_EN : when defined, misaligned word or halfword accesses are
//                    rejected as illegal and never reach memory.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          core request handshake (ready only in IDLE)
//   req_wr, req_ctrl             store flag, access-type code
//   req_addr, req_wdata          byte address, rt value (store data / merge source)
//   mem_addr                     word-aligned memory address
//   mem_read/mem_write           address-phase request, accepted by mem_addr_ready
//   mem_wdata, mem_strb          lane-aligned store data and byte enables
//   mem_rdata, mem_rdata_valid   read data returned by memory
//   mem_rdata_ready              controller waiting for read data
//   resp_valid/resp_ready        response handshake toward the core
//   resp_data, resp_err          load result (0 for stores/errors), error flag
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [3:0]  req_ctrl,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_addr_ready,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_strb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid,
  output logic        mem_rdata_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  // Counter only needs to hold values 0 .. TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_RDATA,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic               wr_q, wr_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               timeout_hit;
  logic [35:0]        lanes;

  // Request legality: unknown codes, store-only codes on a load, load-only
  // codes on a store, and (optionally) misaligned word/half accesses.
  function automatic logic req_illegal(input logic wr, input logic [3:0] ctrl,
                                       input logic [1:0] ea);
    logic bad;
    bad = (ctrl > 4'b1010);
    if (!wr && (ctrl >= 4'b0111) && (ctrl <= 4'b1010)) bad = 1'b1;
    if (wr && (ctrl >= 4'b0001) && (ctrl <= 4'b0110)) bad = 1'b1;
    if (ALIGN_CHK && (ctrl == 4'b0000) && (ea != 2'b00)) bad = 1'b1;
    if (ALIGN_CHK && ((ctrl == 4'b0001) || (ctrl == 4'b0010) || (ctrl == 4'b1010)) && ea[0])
      bad = 1'b1;
    return bad;
  endfunction

  // Store lane placement, little-endian. Returns {strb, data}.
  // swl writes the top (ea+1) bytes of rt into bytes 0..ea;
  // swr writes the low (4-ea) bytes of rt into bytes ea..3.
  function automatic logic [35:0] store_lanes(input logic [3:0] ctrl, input logic [1:0] ea,
                                              input logic [31:0] wd);
    logic [3:0]  strb;
    logic [31:0] data;
    case (ctrl)
      4'b1001: begin
        strb = 4'b0001 << ea;
        data = wd << {ea, 3'b000};
      end
      4'b1010: begin
        strb = ea[1] ? 4'b1100 : 4'b0011;
        data = ea[1] ? {wd[15:0], 16'h0000} : {16'h0000, wd[15:0]};
      end
      4'b0111: begin
        case (ea)
          2'd0:    strb = 4'b0001;
          2'd1:    strb = 4'b0011;
          2'd2:    strb = 4'b0111;
          default: strb = 4'b1111;
        endcase
        data = wd >> {~ea, 3'b000};
      end
      4'b1000: begin
        strb = 4'b1111 << ea;
        data = wd << {ea, 3'b000};
      end
      default: begin
        strb = 4'b1111;
        data = wd;
      end
    endcase
    return {strb, data};
  endfunction

  // Load extension/merge, little-endian. lwl/lwr keep the rt bytes that the
  // memory word does not cover.
  function automatic logic [31:0] load_extend(input logic [3:0] ctrl, input logic [1:0] ea,
                                              input logic [31:0] rd, input logic [31:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (ea)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = ea[1] ? rd[31:16] : rd[15:0];
    case (ctrl)
      4'b0001: r = {{16{h[15]}}, h};
      4'b0010: r = {16'h0000, h};
      4'b0011: r = {{24{b[7]}}, b};
      4'b0100: r = {24'h000000, b};
      4'b0101: r = (rd << {~ea, 3'b000}) | (rt & ~(32'hFFFF_FFFF << {~ea, 3'b000}));
      4'b0110: r = (rd >> {ea, 3'b000}) | (rt & ~(32'hFFFF_FFFF >> {ea, 3'b000}));
      default: r = rd;
    endcase
    return r;
  endfunction

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign lanes       = store_lanes(ctrl_q, addr_q[1:0], wdata_q);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_wr;
          ctrl_d  = req_ctrl;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          rdata_d = '0;
          if (req_illegal(req_wr, req_ctrl, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (mem_addr_ready) begin
          cnt_d = '0;
          if (wr_q) begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = S_RESP;
          end else begin
            state_d = S_RDATA;
          end
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RDATA: begin
        if (mem_rdata_valid) begin
          rdata_d = load_extend(ctrl_q, addr_q[1:0], mem_rdata, wdata_q);
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      ctrl_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs are pure state decodes; address/data buses are zero outside the
  // phase that owns them so nothing stale leaks onto the memory bus.
  always_comb begin
    req_ready       = (state_q == S_IDLE);
    mem_read        = (state_q == S_ADDR) && !wr_q;
    mem_write       = (state_q == S_ADDR) && wr_q;
    mem_addr        = (state_q == S_ADDR) ? {addr_q[31:2], 2'b00} : 32'h0;
    mem_wdata       = mem_write ? lanes[31:0] : 32'h0;
    mem_strb        = mem_write ? lanes[35:32] : 4'h0;
    mem_rdata_ready = (state_q == S_RDATA);
    resp_valid      = (state_q == S_RESP);
    resp_data       = (state_q == S_RESP) ? rdata_q : 32'h0;
    resp_err        = (state_q == S_RESP) && err_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  localparam int unsigned TO = 4;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr;
  logic [3:0]  req_ctrl;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] mem_addr;
  logic        mem_read, mem_write, mem_addr_ready;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid, mem_rdata_ready;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr_ready(mem_addr_ready), .mem_wdata(mem_wdata), .mem_strb(mem_strb),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .mem_rdata_ready(mem_rdata_ready), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err)
  );

  typedef struct {
    bit          rr, mr, mw, rdr, rv;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model (byte-level rules) ----------------
  function automatic bit m_illegal(input bit wr, input logic [3:0] c, input logic [1:0] ea);
    bit bad;
    bad = (c > 4'd10) || (!wr && c >= 4'd7) || (wr && c >= 4'd1 && c <= 4'd6);
    if (ALIGN && c == 4'd0 && ea != 2'd0) bad = 1'b1;
    if (ALIGN && (c == 4'd1 || c == 4'd2 || c == 4'd10) && ea[0]) bad = 1'b1;
    return bad;
  endfunction

  task automatic m_store(input logic [3:0] c, input logic [1:0] ea, input logic [31:0] rt,
                         output logic [3:0] strb, output logic [31:0] data);
    int e;
    e = int'(ea);
    strb = 4'h0;
    data = 32'h0;
    for (int i = 0; i < 4; i++) begin
      int src;
      src = -1;
      case (c)
        4'd0:    src = i;
        4'd9:    if (i == e) src = 0;
        4'd10:   if (i / 2 == e / 2) src = i % 2;
        4'd7:    if (i <= e) src = i + 3 - e;
        4'd8:    if (i >= e) src = i - e;
        default: src = -1;
      endcase
      if (src >= 0) begin
        strb[i] = 1'b1;
        data[8*i +: 8] = rt[8*src +: 8];
      end
    end
  endtask

  function automatic logic [31:0] m_load(input logic [3:0] c, input logic [1:0] ea,
                                         input logic [31:0] rd, input logic [31:0] rt);
    int e;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    e = int'(ea);
    b = rd[8*e +: 8];
    h = rd[16*(e/2) +: 16];
    r = rd;
    case (c)
      4'd1: r = {{16{h[15]}}, h};
      4'd2: r = {16'h0, h};
      4'd3: r = {{24{b[7]}}, b};
      4'd4: r = {24'h0, b};
      4'd5: for (int j = 0; j < 4; j++)
              r[8*j +: 8] = (j >= 3 - e) ? rd[8*(j-3+e) +: 8] : rt[8*j +: 8];
      4'd6: for (int j = 0; j < 4; j++)
              r[8*j +: 8] = (j <= 3 - e) ? rd[8*(j+e) +: 8] : rt[8*j +: 8];
      default: r = rd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic exp_t blank();
    exp_t e;
    e.rr = 0; e.mr = 0; e.mw = 0; e.rdr = 0; e.rv = 0;
    e.addr = 0; e.wdata = 0; e.strb = 0; e.rdata = 0; e.err = 0;
    return e;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ce = exp_q.pop_front();
      chk("handshake{rr,mr,mw,rdr,rv}",
          {27'h0, req_ready, mem_read, mem_write, mem_rdata_ready, resp_valid},
          {27'h0, ce.rr, ce.mr, ce.mw, ce.rdr, ce.rv});
      if (ce.mr || ce.mw) chk("mem_addr", mem_addr, ce.addr);
      if (ce.mw) begin
        chk("mem_strb", {28'h0, mem_strb}, {28'h0, ce.strb});
        chk("mem_wdata", mem_wdata & lane_mask(ce.strb), ce.wdata);
      end
      if (ce.rv) begin
        chk("resp_data", resp_data, ce.rdata);
        chk("resp_err", {31'h0, resp_err}, {31'h0, ce.err});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic noise();
    req_valid       = 1'($urandom);
    req_wr          = 1'($urandom);
    req_ctrl        = 4'($urandom);
    req_addr        = $urandom;
    req_wdata       = $urandom;
    mem_addr_ready  = 1'($urandom);
    mem_rdata_valid = 1'($urandom);
    mem_rdata       = $urandom;
    resp_ready      = 1'($urandom);
  endtask

  // Inputs are set at posedge+1; expectation is checked at the next negedge.
  task automatic cyc(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    exp_t e;
    noise();
    req_valid = 1'b0;
    e = blank();
    e.rr = 1;
    cyc(e);
  endtask

  task automatic run_txn(input bit wr, input logic [3:0] c, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int as, input int rs, input int ps);
    exp_t        e;
    logic [3:0]  strb;
    logic [31:0] data, res;
    bit          err, done;
    noise();
    req_valid = 1'b1; req_wr = wr; req_ctrl = c; req_addr = addr; req_wdata = wd;
    e = blank();
    e.rr = 1;
    cyc(e);
    res = 32'h0;
    err = 1'b1;
    if (!m_illegal(wr, c, addr[1:0])) begin
      m_store(c, addr[1:0], wd, strb, data);
      done = 1'b0;
      for (int k = 0; k < 64 && !done; k++) begin
        noise();
        mem_addr_ready = (k == as);
        e = blank();
        e.mr = !wr; e.mw = wr; e.addr = {addr[31:2], 2'b00}; e.strb = strb; e.wdata = data;
        cyc(e);
        if (k == as) begin
          done = 1'b1;
          if (wr) err = 1'b0;
        end else if (k + 1 == int'(TO)) begin
          done = 1'b1;
          as = -1;
        end
      end
      if (!wr && as >= 0) begin
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
          noise();
          mem_rdata_valid = (k == rs);
          if (k == rs) mem_rdata = rd;
          e = blank();
          e.rdr = 1;
          cyc(e);
          if (k == rs) begin
            done = 1'b1;
            err = 1'b0;
            res = m_load(c, addr[1:0], rd, wd);
          end else if (k + 1 == int'(TO)) begin
            done = 1'b1;
          end
        end
      end
    end
    for (int k = 0; k <= ps; k++) begin
      noise();
      resp_ready = (k == ps);
      e = blank();
      e.rv = 1; e.rdata = res; e.err = err;
      cyc(e);
    end
  endtask

  function automatic int pick();
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : 0;
  endfunction

  initial begin
    logic [3:0]  ps_strb;
    logic [31:0] ps_data;
    logic [31:0] exp_ill;

    rst = 1'b1;
    req_valid = 0; req_wr = 0; req_ctrl = 0; req_addr = 0; req_wdata = 0;
    mem_addr_ready = 0; mem_rdata_valid = 0; mem_rdata = 0; resp_ready = 0;
    #2;
    chk("rst req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst controls", {28'h0, mem_read, mem_write, mem_rdata_ready, resp_valid}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_strb", {28'h0, mem_strb}, 32'h0);
    chk("rst resp", {resp_data[30:0], resp_err} | {31'h0, resp_data[31]}, 32'h0);

    // Hand-computed pins of the model.
    chk("pin lb", m_load(4'd3, 2'd3, 32'h80112233, 32'h0), 32'hFFFFFF80);
    chk("pin lwl", m_load(4'd5, 2'd0, 32'h11223344, 32'hAABBCCDD), 32'h44BBCCDD);
    chk("pin lwr", m_load(4'd6, 2'd1, 32'h11223344, 32'hAABBCCDD), 32'hAA112233);
    chk("pin lh", m_load(4'd1, 2'd2, 32'h80112233, 32'h0), 32'hFFFF8011);
    m_store(4'd10, 2'd2, 32'h0000BEEF, ps_strb, ps_data);
    chk("pin sh strb", {28'h0, ps_strb}, 32'hC);
    chk("pin sh data", ps_data, 32'hBEEF0000);
    m_store(4'd7, 2'd1, 32'hAABBCCDD, ps_strb, ps_data);
    chk("pin swl", {ps_strb, ps_data[27:0]}, {4'b0011, 28'h000AABB});
    exp_ill = ALIGN ? 32'h1 : 32'h0;
    chk("pin lw misalign", {31'h0, m_illegal(1'b0, 4'd0, 2'd2)}, exp_ill);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed scenarios.
    run_txn(1'b0, 4'd3,  32'h1003, 32'h0, 32'h80112233, 0, 0, 0);
    run_txn(1'b1, 4'd10, 32'h2002, 32'h0000BEEF, 32'h0, 0, 0, 0);
    run_txn(1'b0, 4'd5,  32'h0010, 32'hAABBCCDD, 32'h11223344, 0, 0, 0);
    run_txn(1'b0, 4'd0,  32'h0100, 32'h0, 32'h0, 0, 100, 0);
    run_txn(1'b1, 4'd9,  32'h0200, 32'h5A, 32'h0, 100, 0, 2);
    run_txn(1'b0, 4'd0,  32'h0006, 32'h0, 32'hCAFEF00D, 0, 0, 0);
    run_txn(1'b0, 4'd11, 32'h0000, 32'h0, 32'h0, 0, 0, 1);
    run_txn(1'b0, 4'd8,  32'h0000, 32'h0, 32'h0, 0, 0, 0);
    run_txn(1'b1, 4'd2,  32'h0000, 32'h0, 32'h0, 0, 0, 0);
    idle_cycle();

    // Reset while the address phase is stalled.
    noise();
    req_valid = 1'b1; req_wr = 1'b0; req_ctrl = 4'd0; req_addr = 32'h40;
    ce = blank();
    ce.rr = 1;
    cyc(ce);
    noise();
    mem_addr_ready = 1'b0;
    #1;
    chk("pre-rst mem_read", {31'h0, mem_read}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async rst controls", {27'h0, req_ready, mem_read, mem_write, mem_rdata_ready, resp_valid},
        32'h10);
    chk("async rst mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) idle_cycle();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      run_txn(1'($urandom), 4'($urandom_range(0, 11)), $urandom, $urandom, $urandom,
              pick(), pick(), pick());
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
